// File: rtl/beta_dmem_responder.sv
// Fixed-latency data-memory responder for the Beta core: IDLE -> WAIT -> RESP handshake
// in front of a word-addressed store. Define BETA_DMEM_FAULT_EN to enable address/request fault checks.
module beta_dmem_responder #(
    parameter int ADDR_WORDS  = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] DataAddress,
    input  logic [31:0] DataWrite,
    input  logic        WriteEnable,
    input  logic        ReadEnable,
    output logic [31:0] DataRead,
    output logic        dataReady,
    output logic        dMemfault
);
    localparam int IDXW = $clog2(ADDR_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, stateNext;
    logic [3:0]  cnt, cntNext;
    logic [31:0] addrQ, dataQ;
    logic        rdQ, wrQ;
    logic [31:0] mem [ADDR_WORDS];

    logic            accept, commit;
    logic [31:0]     reqAddr, reqData;
    logic            reqRd, reqWr, reqFault;
    logic [IDXW-1:0] reqIdx;

    // In IDLE the live inputs describe the request; afterwards only the latched copy counts.
    always_comb begin
        accept  = (state == IDLE) && (ReadEnable || WriteEnable);
        reqAddr = (state == IDLE) ? DataAddress : addrQ;
        reqData = (state == IDLE) ? DataWrite   : dataQ;
        reqRd   = (state == IDLE) ? ReadEnable  : rdQ;
        reqWr   = (state == IDLE) ? WriteEnable : wrQ;
        reqIdx  = reqAddr[IDXW+1:2];
    end

`ifdef BETA_DMEM_FAULT_EN
    assign reqFault = (reqAddr[1:0] != 2'b00) || (reqAddr[31:IDXW+2] != '0) || (reqRd && reqWr);
`else
    // Out-of-range index bits and byte offset are dropped: the index wraps.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{reqAddr[31:IDXW+2], reqAddr[1:0]};
    assign reqFault       = 1'b0;
`endif

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: if (accept) begin
                cntNext   = 4'(WAIT_STATES);
                stateNext = (WAIT_STATES == 0) ? RESP : WAIT;
            end
            WAIT: begin
                cntNext = 4'(cnt - 4'd1);
                if (cnt <= 4'd1) stateNext = RESP;
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        commit = (stateNext == RESP) && (state != RESP) && reqWr && !reqFault;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dataReady <= 1'b0;
            dMemfault <= 1'b0;
            DataRead  <= '0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            dataReady <= (state == RESP);
            dMemfault <= (state == RESP) && reqFault;
            DataRead  <= ((state == RESP) && reqRd && !reqWr && !reqFault) ? mem[reqIdx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addrQ <= DataAddress;
            dataQ <= DataWrite;
            rdQ   <= ReadEnable;
            wrQ   <= WriteEnable;
        end
    end

    // Storage is deliberately not reset; a reset edge blocks a pending commit.
    always_ff @(posedge clk) begin
        if (!rst && commit) mem[reqIdx] <= reqData;
    end
endmodule

// File: doc/beta_dmem_responder.md
BETA_DMEM_RESPONDER -- requirements
Module: beta_dmem_responder

Interface
REQ-001 Parameter ADDR_WORDS, default 1024, gives the number of 32-bit words in backing storage (power of two, 16..65536).
REQ-002 Parameter WAIT_STATES, default 2, gives the added response latency in cycles (0..15).
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 DataAddress  input  32  byte address from the core.
REQ-006 DataWrite  input  32  store data from the core.
REQ-007 WriteEnable  input  1  store request.
REQ-008 ReadEnable  input  1  load request.
REQ-009 DataRead  output  32  load data, valid only while dataReady is high.
REQ-010 dataReady  output  1  one-cycle completion pulse for the current request.
REQ-011 dMemfault  output  1  fault flag, qualified by dataReady.

Function
REQ-012 The block SHALL implement three states: IDLE, WAIT and RESP.
REQ-013 In IDLE with ReadEnable or WriteEnable high, the block SHALL latch address, data and request type, load the wait counter with WAIT_STATES, and go to WAIT (or to RESP when WAIT_STATES=0).
REQ-014 In WAIT the counter SHALL decrement once per cycle; on the cycle it reaches 1 the block SHALL move to RESP.
REQ-015 For a request accepted at edge T, dataReady SHALL be high for exactly the cycle following edge T+1+WAIT_STATES, then the block SHALL return to IDLE.
REQ-016 The requester holds inputs stable until dataReady; inputs changing during WAIT/RESP SHALL be ignored, because latched values are used.
REQ-017 A read response SHALL present mem[word index] on DataRead; all other cycles, including write and fault responses, SHALL drive DataRead=0.
REQ-018 A write SHALL commit to storage at the edge that enters RESP, and only if it is not faulted.
REQ-019 The word index SHALL be DataAddress[31:2]; DataAddress[1:0] SHALL NOT select bytes.
REQ-020 A new request SHALL be accepted on the first IDLE cycle after RESP, giving a back-to-back throughput of one request per WAIT_STATES+2 cycles.
REQ-021 Storage contents SHALL NOT be initialized by rst.

Reset
REQ-022 When rst is high at an edge, the block SHALL enter IDLE and clear dataReady, dMemfault and DataRead to 0, and the counter to 0.
REQ-023 A reset mid-operation (WAIT or RESP) SHALL abort the request: no write commit, no dataReady pulse.
REQ-024 A request held high across reset deassertion SHALL be accepted on the first cycle after rst falls.

Configuration
REQ-025 With macro BETA_DMEM_FAULT_EN defined, the block SHALL raise dMemfault together with dataReady, and suppress any write, when any of the following holds:
- DataAddress[1:0] is not 0;
- the word index is >= ADDR_WORDS;
- ReadEnable and WriteEnable were both high at acceptance.
REQ-026 Without BETA_DMEM_FAULT_EN, dMemfault SHALL be constant 0, the word index SHALL wrap modulo ADDR_WORDS, low address bits SHALL be ignored, and simultaneous enables SHALL perform the write, with DataRead=0.
REQ-027 Fault timing SHALL equal normal response timing in both builds.

Verification
REQ-028 WAIT_STATES=2: write 0xDEADBEEF to 0x10 at cycle 0, then read 0x10 -> dataReady at cycle 3 each time, read returns 0xDEADBEEF, dMemfault=0.
REQ-029 WAIT_STATES=0: read held continuously for 4 requests -> dataReady pulses on alternate cycles, never two consecutive cycles.
REQ-030 FAULT_EN: read 0x13 -> dataReady=1, dMemfault=1, DataRead=0; write 0x1000 with ADDR_WORDS=1024 -> fault, and a later read of 0x0 is unchanged.
REQ-031 No FAULT_EN, ADDR_WORDS=1024: write 0x1234 to 0x1004 -> a read of 0x4 returns 0x1234; dMemfault is never 1.
REQ-032 Write 0x55 to 0x20, assert rst during WAIT -> no dataReady pulse; after reset a read of 0x20 returns its previous value, not 0x55.
REQ-033 Change DataAddress from 0x20 to 0x40 during WAIT of a read -> the response returns mem[0x20].
